// File: rtl/sb_defs.sv
// sb_defs: shared FSM encodings, default sizes and pointer-width helper for the store buffer
package sb_defs;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_GAP = 2'd2} sb_state_e;
  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 16;
  localparam int SB_DATA_W = 16;
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/store_fifo.sv
// store_fifo: circular store storage with head/tail/count and per-entry valid/addr/data read-out
module store_fifo
  import sb_defs::*;
#(
  parameter  int DEPTH  = SB_DEPTH,
  parameter  int ADDR_W = SB_ADDR_W,
  parameter  int DATA_W = SB_DATA_W,
  localparam int PW     = ptr_w(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic [ADDR_W-1:0]             push_addr_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  output logic [PW-1:0]                 head_ptr_o,
  output logic [DEPTH-1:0]              valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  addr_o,
  output logic [DEPTH-1:0][DATA_W-1:0]  data_o,
  output logic [CW-1:0]                 count_o,
  output logic                          full_o,
  output logic                          empty_o
);
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic do_push, do_pop;
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_comb begin
    head_d  = do_pop ? head_q + PW'(1) : head_q;
    tail_d  = do_push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    valid_d = valid_q;
    if (do_pop) valid_d[head_q] = 1'b0;
    if (do_push) valid_d[tail_q] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
  end
  assign head_ptr_o = head_q;
  assign valid_o    = valid_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign count_o    = count_q;
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer draining stores in order with load forwarding from the youngest match
module store_buffer
  import sb_defs::*;
#(
  parameter  int DEPTH  = SB_DEPTH,
  parameter  int ADDR_W = SB_ADDR_W,
  parameter  int DATA_W = SB_DATA_W,
  localparam int PW     = ptr_w(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_hit,
  output logic              ld_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              empty,
  output logic [CW-1:0]     count
);
  sb_state_e state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [PW-1:0] head_ptr;
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic full, latch, fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  store_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (st_valid),
    .push_addr_i(st_addr),
    .push_data_i(st_data),
    .pop_i      (state_q == S_WRITE),
    .head_ptr_o (head_ptr),
    .valid_o    (ent_valid),
    .addr_o     (ent_addr),
    .data_o     (ent_data),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );
  assign st_ready = !full;
  // a pending load owns the memory port, so it holds off the next write
  assign latch = state_q == S_IDLE && !empty && !ld_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  always_comb begin
    state_d   = latch ? S_WRITE : state_q == S_WRITE ? S_GAP : S_IDLE;
    wr_addr_d = latch ? ent_addr[head_ptr] : wr_addr_q;
    wr_data_d = latch ? ent_data[head_ptr] : wr_data_q;
  end
  always_comb begin
    mem_we    = state_q == S_WRITE;
    mem_addr  = mem_we ? wr_addr_q : ld_valid ? ld_addr : '0;
    mem_wdata = mem_we ? wr_data_q : '0;
    ld_stall  = mem_we && ld_valid;
  end
  // walk oldest to youngest so the last match wins; the head is skipped while it is being written
  always_comb begin
    logic [PW-1:0] idx;
    idx      = head_ptr;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PW'(i);
      if (ent_valid[idx] && ent_addr[idx] == ld_addr && !(state_q == S_WRITE && i == 0)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end
  assign ld_hit  = ld_valid && fwd_hit;
  assign ld_data = ld_hit ? fwd_data : mem_rdata;
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with write/load scoreboards checked by a negedge monitor
module tb_store_buffer;
  logic clk = 1'b0, reset = 1'b1;
  logic st_valid = 1'b0, ld_valid = 1'b0;
  logic [15:0] st_addr = '0, st_data = '0, ld_addr = '0;
  logic st_ready, ld_hit, ld_stall, mem_we, empty;
  logic [15:0] ld_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0] count;
  typedef struct packed {logic [15:0] a; logic [15:0] d;} wr_t;
  typedef struct packed {logic [15:0] d; logic h;} ld_t;
  wr_t wq[$];
  ld_t lq[$];
  logic ld_track = 1'b0, prev_we = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int stalls[5];
  store_buffer dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_hit(ld_hit), .ld_stall(ld_stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .empty(empty), .count(count)
  );
  assign mem_rdata = mem_addr ^ 16'h5A5A;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (empty && !mem_we) break;
    end
    chk(name, 32'(empty && !mem_we), 32'd1);
    chk("write_queue_drained", 32'(wq.size()), 32'd0);
    tick();
  endtask
  always @(negedge clk) begin
    if (mem_we) begin
      chk("we_drops_between_writes", 32'(prev_we), 32'd0);
      n_cmp++;
      if (wq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h, none expected", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if (mem_addr !== e.a || mem_wdata !== e.d) begin
          n_bad++;
          $display("FAIL write_order: got addr %h data %h expected addr %h data %h", mem_addr, mem_wdata, e.a, e.d);
        end
      end
    end
    prev_we = mem_we;
    if (ld_track && ld_valid && !ld_stall) begin
      n_cmp++;
      if (lq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_load: got data %h hit %b, none expected", ld_data, ld_hit);
      end else begin
        ld_t e;
        e = lq.pop_front();
        if (ld_data !== e.d || ld_hit !== e.h) begin
          n_bad++;
          $display("FAIL load_result addr %h: got data %h hit %b expected data %h hit %b", ld_addr, ld_data, ld_hit, e.d, e.h);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    tick();
    tick();
    reset = 1'b0;
    // reset state after idle cycles
    repeat (3) tick();
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_ld_stall", 32'(ld_stall), 32'd0);
    tick();
    // single store drains two cycles after push
    st_valid = 1'b1; st_addr = 16'h0010; st_data = 16'hBEEF;
    wq.push_back('{16'h0010, 16'hBEEF});
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    chk("t2_we_early", 32'(mem_we), 32'd0);
    chk("t2_count", 32'(count), 32'd1);
    tick();
    @(negedge clk);
    chk("t2_we", 32'(mem_we), 32'd1);
    chk("t2_addr", 32'(mem_addr), 32'h0010);
    chk("t2_data", 32'(mem_wdata), 32'hBEEF);
    tick();
    @(negedge clk);
    chk("t2_we_drop", 32'(mem_we), 32'd0);
    chk("t2_empty", 32'(empty), 32'd1);
    tick();
    // five stores with drain held off by a load: fifth waits for the first pop
    ld_valid = 1'b1; ld_addr = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      st_valid = 1'b1; st_addr = 16'h0100 + 16'(k); st_data = 16'hA000 + 16'(k);
      if (k == 4) ld_valid = 1'b0;
      stalls[k] = 0;
      @(negedge clk);
      while (!st_ready && stalls[k] < 20) begin
        stalls[k]++;
        @(negedge clk);
      end
      if (k == 4) chk("t3_full_count", 32'(count), 32'd3);
      wq.push_back('{16'h0100 + 16'(k), 16'hA000 + 16'(k)});
      tick();
    end
    st_valid = 1'b0;
    chk("t3_first4_no_stall", 32'(stalls[0] + stalls[1] + stalls[2] + stalls[3]), 32'd0);
    chk("t3_fifth_stall", 32'(stalls[4]), 32'd2);
    drain("t3_drained");
    // forwarding: youngest match wins, misses read memory, same-cycle store is not seen
    ld_valid = 1'b1; ld_addr = 16'h0000;
    st_valid = 1'b1; st_addr = 16'h0020; st_data = 16'h1111; wq.push_back('{16'h0020, 16'h1111}); tick();
    st_addr = 16'h0020; st_data = 16'h2222; wq.push_back('{16'h0020, 16'h2222}); tick();
    st_addr = 16'h0040; st_data = 16'h3333; wq.push_back('{16'h0040, 16'h3333}); tick();
    st_valid = 1'b0;
    ld_track = 1'b1;
    ld_addr = 16'h0020; lq.push_back('{16'h2222, 1'b1}); tick();
    ld_addr = 16'h0030; lq.push_back('{16'h5A6A, 1'b0}); tick();
    ld_addr = 16'h0040; lq.push_back('{16'h3333, 1'b1}); tick();
    st_valid = 1'b1; st_addr = 16'h0050; st_data = 16'h7777; wq.push_back('{16'h0050, 16'h7777});
    ld_addr = 16'h0050; lq.push_back('{16'h5A0A, 1'b0}); tick();
    st_valid = 1'b0;
    lq.push_back('{16'h7777, 1'b1}); tick();
    ld_track = 1'b0; ld_valid = 1'b0;
    chk("t4_load_queue_drained", 32'(lq.size()), 32'd0);
    drain("t4_drained");
    // load arriving during WRITE stalls exactly one cycle
    st_valid = 1'b1; st_addr = 16'h0060; st_data = 16'hAAAA; wq.push_back('{16'h0060, 16'hAAAA});
    tick();
    st_valid = 1'b0;
    tick();
    ld_valid = 1'b1; ld_addr = 16'h0070;
    @(negedge clk);
    chk("t5_stall", 32'(ld_stall), 32'd1);
    chk("t5_write_addr", 32'(mem_addr), 32'h0060);
    tick();
    @(negedge clk);
    chk("t5_stall_released", 32'(ld_stall), 32'd0);
    chk("t5_we_low", 32'(mem_we), 32'd0);
    chk("t5_load_addr", 32'(mem_addr), 32'h0070);
    chk("t5_load_data", 32'(ld_data), 32'h5A2A);
    tick();
    ld_valid = 1'b0;
    drain("t5_drained");
    // reset in mid-drain discards everything
    ld_valid = 1'b1; ld_addr = 16'h0000;
    st_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      st_addr = 16'h0080 + 16'(k); st_data = 16'h0001 + 16'(k);
      tick();
    end
    st_valid = 1'b0; ld_valid = 1'b0;
    tick();
    chk("t6_in_write", 32'(mem_we), 32'd1);
    chk("t6_write_data", 32'(mem_wdata), 32'h0001);
    chk("t6_count_before", 32'(count), 32'd3);
    reset = 1'b1;
    #1;
    chk("t6_we_dropped", 32'(mem_we), 32'd0);
    chk("t6_count_cleared", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_st_ready", 32'(st_ready), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("t6_still_empty", 32'(empty), 32'd1);
    chk("final_write_queue", 32'(wq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
